// File: rtl/sinfonia_do_espectro_core_pkg.sv
// Shared definitions for the seven-note memory game:
// state codes, melody ROM, note coding, BCD and 7-segment helpers.
package sinfonia_do_espectro_core_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        PREPARACAO     = 5'h01,
        ESPERA_INICIO  = 5'h02,
        MOSTRA_NOTA    = 5'h03,
        APAGA          = 5'h04,
        PROXIMA_NOTA   = 5'h05,
        ZERA_ENDERECO  = 5'h06,
        ESPERA_JOGADA  = 5'h0A,
        REGISTRA       = 5'h0B,
        COMPARA        = 5'h0C,
        ULTIMA         = 5'h0D,
        PROXIMA_RODADA = 5'h0E,
        ACERTO         = 5'h0F,
        GANHOU         = 5'h1C,
        ERRO           = 5'h1E,
        PERDEU         = 5'h1F
    } estado_t;

    localparam int         TIMER_W    = 10;
    localparam logic [3:0] ULTIMO_END = 4'd15;

    function automatic logic [6:0] rom(input logic [3:0] a);
        logic [6:0] n;
        case (a)
            4'd0:    n = 7'h20;
            4'd1:    n = 7'h02;
            4'd2:    n = 7'h08;
            4'd3:    n = 7'h20;
            4'd4:    n = 7'h02;
            4'd5:    n = 7'h08;
            4'd6:    n = 7'h20;
            4'd7:    n = 7'h04;
            4'd8:    n = 7'h01;
            4'd9:    n = 7'h10;
            4'd10:   n = 7'h02;
            4'd11:   n = 7'h08;
            4'd12:   n = 7'h20;
            4'd13:   n = 7'h02;
            4'd14:   n = 7'h08;
            default: n = 7'h20;
        endcase
        return n;
    endfunction

    // Anything that is not exactly one-hot sounds as silence.
    function automatic logic [2:0] codigo_nota(input logic [6:0] n);
        logic [2:0] c;
        case (n)
            7'h01:   c = 3'd1;
            7'h02:   c = 3'd2;
            7'h04:   c = 3'd3;
            7'h08:   c = 3'd4;
            7'h10:   c = 3'd5;
            7'h20:   c = 3'd6;
            7'h40:   c = 3'd7;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    function automatic logic [11:0] to_bcd(input logic [9:0] v);
        logic [21:0] sh;
        sh = {12'd0, v};
        for (int i = 0; i < 10; i++) begin
            if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
            if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
            if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return ~s;
    endfunction

endpackage

// File: rtl/sinfonia_do_espectro_core_uc.sv
// Control unit: sequences playback, player input and round progression.
// Result flags are registered on the transition into their state.
module sinfonia_do_espectro_core_uc
    import sinfonia_do_espectro_core_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    jogar,
    input  logic    treinamento,
    input  logic    press,
    input  logic    fim_tempo,
    input  logic    fim_seq,
    input  logic    fim_jogo,
    input  logic    igual,
    output estado_t Eatual,
    output logic    acertou,
    output logic    errou,
    output logic    pronto
);

    always_ff @(posedge clock) begin
        if (reset) begin
            Eatual  <= INICIAL;
            acertou <= 1'b0;
            errou   <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            unique case (Eatual)
                INICIAL:
                    if (jogar) Eatual <= PREPARACAO;
                PREPARACAO: begin
                    acertou <= 1'b0;
                    errou   <= 1'b0;
                    pronto  <= 1'b0;
                    Eatual  <= ESPERA_INICIO;
                end
                ESPERA_INICIO:
                    if (press) Eatual <= MOSTRA_NOTA;
                MOSTRA_NOTA:
                    if (fim_tempo) Eatual <= APAGA;
                APAGA:
                    if (fim_tempo)
                        Eatual <= fim_seq ? ZERA_ENDERECO : PROXIMA_NOTA;
                PROXIMA_NOTA:
                    Eatual <= MOSTRA_NOTA;
                ZERA_ENDERECO:
                    Eatual <= ESPERA_JOGADA;
                ESPERA_JOGADA:
                    if (press) Eatual <= REGISTRA;
                REGISTRA:
                    Eatual <= COMPARA;
                COMPARA:
                    if (!igual) begin
                        errou  <= 1'b1;
                        Eatual <= ERRO;
                    end else begin
                        Eatual <= fim_seq ? ULTIMA : ACERTO;
                    end
                ACERTO:
                    Eatual <= ESPERA_JOGADA;
                ULTIMA:
                    if (fim_jogo) begin
                        acertou <= 1'b1;
                        pronto  <= 1'b1;
                        Eatual  <= GANHOU;
                    end else begin
                        Eatual  <= PROXIMA_RODADA;
                    end
                PROXIMA_RODADA:
                    if (fim_tempo) Eatual <= MOSTRA_NOTA;
                ERRO:
                    if (!treinamento) begin
                        pronto <= 1'b1;
                        Eatual <= PERDEU;
                    end else if (fim_tempo) begin
                        Eatual <= MOSTRA_NOTA;
                    end
                GANHOU, PERDEU:
                    if (jogar) Eatual <= PREPARACAO;
                default:
                    Eatual <= INICIAL;
            endcase
        end
    end

endmodule

// File: rtl/sinfonia_do_espectro_core.sv
// Game top: button sync, address/limit counters, timer, score and
// debug displays around the control unit.
module sinfonia_do_espectro_core
    import sinfonia_do_espectro_core_pkg::*;
#(
    parameter int NOTE_CYCLES  = 100,
    parameter int GAP_CYCLES   = 10,
    parameter int PAUSE_CYCLES = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        jogar,
    input  logic        treinamento,
    input  logic [6:0]  botoes,
    output logic        pronto,
    output logic        acertou,
    output logic        errou,
    output logic [2:0]  arduino_out,
    output logic [11:0] display,
    output logic        db_clock,
    output logic        db_reset,
    output logic        db_jogar,
    output logic        db_tem_botao_pressionado,
    output logic        db_botoesIgualMemoria,
    output logic [2:0]  db_data_out_sync,
    output logic [6:0]  db_jogada,
    output logic [6:0]  db_memoria,
    output logic [6:0]  db_contagem,
    output logic [6:0]  db_limite,
    output logic [6:0]  db_estado0,
    output logic [6:0]  db_estado1,
    output logic [6:0]  db_ones,
    output logic [6:0]  db_tens,
    output logic [6:0]  db_hundreds
);

    logic [6:0]         b1, b2, jogada, memoria;
    logic               any_ant, press;
    logic [3:0]         addr, limit;
    logic [9:0]         s_pontos;
    logic [TIMER_W-1:0] tempo, limite_tempo;
    logic               tempo_ativo, fim_tempo;
    logic               fim_seq, fim_jogo, igual;
    logic [11:0]        bcd;
    estado_t            Eatual;

    assign memoria  = rom(addr);
    assign press    = (|b2) & ~any_ant;
    assign fim_seq  = (addr == limit);
    assign fim_jogo = (limit == ULTIMO_END);
    assign igual    = (jogada == memoria);

    always_ff @(posedge clock) begin
        if (reset) begin
            b1      <= '0;
            b2      <= '0;
            any_ant <= 1'b0;
            jogada  <= '0;
        end else begin
            b1      <= botoes;
            b2      <= b1;
            any_ant <= |b2;
            if (press) jogada <= b2;
        end
    end

    // One shared timer; it restarts whenever a timed interval expires
    // or the control unit sits in an untimed state.
    assign tempo_ativo = (Eatual == MOSTRA_NOTA) || (Eatual == APAGA) ||
                         (Eatual == PROXIMA_RODADA) ||
                         ((Eatual == ERRO) && treinamento);

    always_comb begin
        limite_tempo = TIMER_W'(PAUSE_CYCLES - 1);
        if (Eatual == MOSTRA_NOTA)
            limite_tempo = TIMER_W'(NOTE_CYCLES - 1);
        else if (Eatual == APAGA)
            limite_tempo = TIMER_W'(GAP_CYCLES - 1);
    end

    assign fim_tempo = tempo_ativo && (tempo == limite_tempo);

    always_ff @(posedge clock) begin
        if (reset)
            tempo <= '0;
        else if (tempo_ativo && !fim_tempo)
            tempo <= tempo + 1'b1;
        else
            tempo <= '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr     <= '0;
            limit    <= '0;
            s_pontos <= '0;
        end else begin
            case (Eatual)
                PREPARACAO: begin
                    addr     <= '0;
                    limit    <= '0;
                    s_pontos <= '0;
                end
                PROXIMA_NOTA:  addr <= addr + 1'b1;
                ZERA_ENDERECO: addr <= '0;
                ACERTO: begin
                    addr     <= addr + 1'b1;
                    s_pontos <= s_pontos + 1'b1;
                end
                ULTIMA: s_pontos <= s_pontos + 1'b1;
                PROXIMA_RODADA: begin
                    addr <= '0;
                    if (fim_tempo) limit <= limit + 1'b1;
                end
                ERRO: addr <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        arduino_out = 3'd0;
        if (Eatual == MOSTRA_NOTA)
            arduino_out = codigo_nota(memoria);
        else if (Eatual == REGISTRA)
            arduino_out = codigo_nota(jogada);
    end

    always_ff @(posedge clock) begin
        if (reset) db_data_out_sync <= 3'd0;
        else       db_data_out_sync <= arduino_out;
    end

    sinfonia_do_espectro_core_uc UC (
        .clock       (clock),
        .reset       (reset),
        .jogar       (jogar),
        .treinamento (treinamento),
        .press       (press),
        .fim_tempo   (fim_tempo),
        .fim_seq     (fim_seq),
        .fim_jogo    (fim_jogo),
        .igual       (igual),
        .Eatual      (Eatual),
        .acertou     (acertou),
        .errou       (errou),
        .pronto      (pronto)
    );

    assign bcd     = to_bcd(s_pontos);
    assign display = bcd;

    assign db_clock                 = clock;
    assign db_reset                 = reset;
    assign db_jogar                 = jogar;
    assign db_tem_botao_pressionado = |botoes;
    assign db_botoesIgualMemoria    = igual;
    assign db_jogada                = jogada;
    assign db_memoria               = memoria;
    assign db_contagem              = seg7(addr);
    assign db_limite                = seg7(limit);
    assign db_estado0               = seg7(Eatual[3:0]);
    assign db_estado1               = seg7({3'd0, Eatual[4]});
    assign db_ones                  = seg7(bcd[3:0]);
    assign db_tens                  = seg7(bcd[7:4]);
    assign db_hundreds              = seg7(bcd[11:8]);

endmodule

// File: tb/tb_sinfonia_do_espectro_core.sv
// Directed bench for the memory game: full win, loss, training replay
// and mid-playback reset, with score and note scoreboards.
module tb_sinfonia_do_espectro_core;

    localparam int NOTE = 100;
    localparam int GAP  = 10;

    logic        clock = 1'b0;
    logic        reset, jogar, treinamento;
    logic [6:0]  botoes;
    logic        pronto, acertou, errou;
    logic [2:0]  arduino_out, db_data_out_sync;
    logic [11:0] display;
    logic        db_clock, db_reset, db_jogar;
    logic        db_tem_botao_pressionado, db_botoesIgualMemoria;
    logic [6:0]  db_jogada, db_memoria, db_contagem, db_limite;
    logic [6:0]  db_estado0, db_estado1, db_ones, db_tens, db_hundreds;

    int errors = 0;
    int checks = 0;
    int pts    = 0;
    int q_pts[$];
    int q_code[$];

    logic [6:0] melody [16] = '{
        7'h20, 7'h02, 7'h08, 7'h20, 7'h02, 7'h08, 7'h20, 7'h04,
        7'h01, 7'h10, 7'h02, 7'h08, 7'h20, 7'h02, 7'h08, 7'h20
    };

    sinfonia_do_espectro_core dut (
        .clock                    (clock),
        .reset                    (reset),
        .jogar                    (jogar),
        .treinamento              (treinamento),
        .botoes                   (botoes),
        .pronto                   (pronto),
        .acertou                  (acertou),
        .errou                    (errou),
        .arduino_out              (arduino_out),
        .display                  (display),
        .db_clock                 (db_clock),
        .db_reset                 (db_reset),
        .db_jogar                 (db_jogar),
        .db_tem_botao_pressionado (db_tem_botao_pressionado),
        .db_botoesIgualMemoria    (db_botoesIgualMemoria),
        .db_data_out_sync         (db_data_out_sync),
        .db_jogada                (db_jogada),
        .db_memoria               (db_memoria),
        .db_contagem              (db_contagem),
        .db_limite                (db_limite),
        .db_estado0               (db_estado0),
        .db_estado1               (db_estado1),
        .db_ones                  (db_ones),
        .db_tens                  (db_tens),
        .db_hundreds              (db_hundreds)
    );

    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic int code_of(input logic [6:0] n);
        for (int i = 0; i < 7; i++)
            if (n == (7'(1) << i)) return i + 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [4:0] s, input int budget,
                              input string tag);
        int n = 0;
        while (dut.UC.Eatual !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(dut.UC.Eatual), 32'(s));
    endtask

    // Edge is seen two clocks after the buttons change; the
    // third clock moves the control unit on.
    task automatic press(input logic [6:0] n);
        botoes = n;
        repeat (3) tick();
        botoes = '0;
    endtask

    task automatic check_playback(input int r);
        int n;
        for (int i = 0; i <= r; i++)
            q_code.push_back(code_of(melody[i]));
        for (int i = 0; i <= r; i++) begin
            wait_state(5'h03, 2000, "wait_note");
            check("note_code", 32'(arduino_out), 32'(q_code.pop_front()));
            n = 0;
            while (dut.UC.Eatual === 5'h03 && n < 300) begin
                n++;
                tick();
            end
            check("note_len", n, NOTE);
            check("gap_silent", 32'(arduino_out), 0);
            n = 0;
            while (dut.UC.Eatual === 5'h04 && n < 100) begin
                n++;
                tick();
            end
            check("gap_len", n, GAP);
        end
    endtask

    task automatic play_note(input logic [6:0] n, input bit ok);
        int k = 0;
        if (ok) pts++;
        q_pts.push_back(pts);
        wait_state(5'h0A, 100, "wait_jogada");
        press(n);
        while (dut.UC.Eatual inside {5'h0B, 5'h0C, 5'h0F, 5'h0D} &&
               k < 20) begin
            tick();
            k++;
        end
        check("pontos", 32'(dut.s_pontos), 32'(q_pts.pop_front()));
    endtask

    initial begin
        reset       = 1'b1;
        jogar       = 1'b0;
        treinamento = 1'b0;
        botoes      = '0;
        tick();
        check("rst_state", 32'(dut.UC.Eatual), 32'h00);
        check("rst_pontos", 32'(dut.s_pontos), 0);
        check("rst_display", 32'(display), 0);
        check("rst_pronto", 32'(pronto), 0);
        check("rst_arduino", 32'(arduino_out), 0);
        check("rst_seg_ones", 32'(db_ones), 32'h40);
        reset = 1'b0;
        tick();

        // Perfect game through all sixteen rounds.
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        wait_state(5'h02, 10, "wait_inicio");
        press(7'h01);
        for (int r = 0; r < 16; r++) begin
            check_playback(r);
            for (int i = 0; i <= r; i++)
                play_note(melody[i], 1'b1);
        end
        wait_state(5'h1C, 20, "ganhou");
        check("win_acertou", 32'(acertou), 1);
        check("win_pronto", 32'(pronto), 1);
        check("win_errou", 32'(errou), 0);
        check("win_display", 32'(display), 32'h136);
        check("win_pontos", 32'(dut.s_pontos), 136);

        // Restart, then lose on the first note.
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        wait_state(5'h02, 10, "restart");
        check("restart_pontos", 32'(dut.s_pontos), 0);
        check("restart_acertou", 32'(acertou), 0);
        check("restart_pronto", 32'(pronto), 0);
        pts = 0;
        press(7'h01);
        check_playback(0);
        play_note(7'h02, 1'b0);
        wait_state(5'h1F, 20, "perdeu");
        check("lose_errou", 32'(errou), 1);
        check("lose_pronto", 32'(pronto), 1);
        check("lose_acertou", 32'(acertou), 0);
        check("lose_display", 32'(display), 0);

        // Training: multi-hot wrong note in round 3 replays it.
        treinamento = 1'b1;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        wait_state(5'h02, 10, "train_start");
        pts = 0;
        press(7'h01);
        for (int r = 0; r < 2; r++) begin
            check_playback(r);
            for (int i = 0; i <= r; i++)
                play_note(melody[i], 1'b1);
        end
        check_playback(2);
        play_note(melody[0], 1'b1);
        play_note(7'h22, 1'b0);
        wait_state(5'h1E, 5, "train_erro");
        check("train_errou", 32'(errou), 1);
        check("train_pronto", 32'(pronto), 0);
        check_playback(2);
        check("train_limit", 32'(db_limite), 32'h24);
        for (int i = 0; i <= 2; i++)
            play_note(melody[i], 1'b1);
        wait_state(5'h0E, 5, "train_next");
        check("train_display", 32'(display), 32'h007);

        // Reset while a note is sounding.
        wait_state(5'h03, 2000, "pre_reset_note");
        check("pre_reset_code", 32'(arduino_out), 6);
        reset = 1'b1;
        tick();
        check("mid_rst_state", 32'(dut.UC.Eatual), 32'h00);
        check("mid_rst_arduino", 32'(arduino_out), 0);
        check("mid_rst_pontos", 32'(dut.s_pontos), 0);
        check("mid_rst_errou", 32'(errou), 0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
